rv_boot_seq: RTL

Boot sequencer for the RISC-V core cluster. It releases per-core resets one at a time, in index order, with a programmable gap between releases. The per-core reset vectors are already programmed in the AXI CSR block. After release it watches each core's PC and flags cores whose PC stops changing. It sits between the CSR block (which supplies the start, mask and config fields and reads back status) and the per-core reset inputs.

---
 rtl/rv_boot_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/rv_boot_seq.sv
// rv_boot_seq: staggered per-core reset release with a per-core PC-stall watchdog.
module rv_boot_seq #(
  parameter int N_CORES = 4,
  parameter int GAP_W   = 16,
  parameter int WDOG_W  = 16
) (
  input  logic                  aclk,
  input  logic                  arstn,
  input  logic                  boot_start,
  input  logic                  abort,
  input  logic [N_CORES-1:0]    core_mask,
  input  logic [GAP_W-1:0]      gap_cfg,
  input  logic [WDOG_W-1:0]     stall_limit,
  input  logic [32*N_CORES-1:0] core_pc,
  output logic [N_CORES-1:0]    core_rstn,
  output logic [N_CORES-1:0]    core_hung,
  output logic                  boot_busy,
  output logic                  boot_done
);
  localparam int IW = N_CORES > 1 ? $clog2(N_CORES) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_CORES - 1);
  typedef enum logic [2:0] {IDLE, STEP, WAIT, DONE, RUN} state_t;
  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [GAP_W-1:0]     cnt_q, cnt_d, gap_q, gap_d;
  logic [N_CORES-1:0]   mask_q, mask_d, rstn_q, rstn_d, hung_q;
  logic [WDOG_W-1:0]    wcnt_q [N_CORES];
  logic [31:0]          pc_q   [N_CORES];
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      mask_q  <= '0;
      rstn_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      mask_q  <= mask_d;
      rstn_q  <= rstn_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    mask_d  = mask_q;
    rstn_d  = rstn_q;
    case (state_q)
      IDLE: if (boot_start) begin
        mask_d  = core_mask;
        gap_d   = gap_cfg;
        idx_d   = '0;
        state_d = STEP;
      end
      STEP: begin
        if (mask_q[idx_q]) rstn_d[idx_q] = 1'b1;
        if (idx_q == LAST) state_d = DONE;
        else begin
          idx_d = idx_q + 1'b1;
          if (mask_q[idx_q] && gap_q != '0) begin
            cnt_d   = gap_q;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == GAP_W'(1)) state_d = STEP;
      end
      DONE:    state_d = RUN;
      default: state_d = state_q;
    endcase
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      rstn_d  = '0;
    end
  end
  // Compare is one bit wider so a saturated counter never wraps into a match.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      hung_q <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        wcnt_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        pc_q[i] <= core_pc[32*i +: 32];
        if (abort) begin
          wcnt_q[i] <= '0;
          hung_q[i] <= 1'b0;
        end else if (!rstn_q[i] || core_pc[32*i +: 32] != pc_q[i]) begin
          wcnt_q[i] <= '0;
        end else begin
          wcnt_q[i] <= &wcnt_q[i] ? wcnt_q[i] : wcnt_q[i] + 1'b1;
          if (stall_limit != '0 && ({1'b0, wcnt_q[i]} + 1'b1) == {1'b0, stall_limit})
            hung_q[i] <= 1'b1;
        end
      end
    end
  end
  assign core_rstn = rstn_q;
  assign core_hung = hung_q;
  assign boot_busy = state_q == STEP || state_q == WAIT || state_q == DONE;
  assign boot_done = state_q == DONE;
endmodule
